// File: rtl/aes_seq_ctrl.sv
// AES-128 encrypt sequencer: drives an external combinational round unit for
// ten rounds, then writes the ciphertext back to the register file one 32-bit
// word per cycle, yielding to the pipeline's own WB writes.
module aes_seq_ctrl #(
  parameter int unsigned WR_WORDS = 4
) (
  input  logic         in_clk,
  input  logic         in_rst,
  input  logic         in_start,
  input  logic [127:0] in_cipherkey,
  input  logic [127:0] in_state,
  input  logic [4:0]   in_dst_base,
  input  logic         in_wb_regWrite,
  input  logic [127:0] in_rnd_state_next,
  input  logic [127:0] in_rnd_key_next,
  output logic [127:0] out_rnd_state,
  output logic [127:0] out_rnd_key,
  output logic [7:0]   out_rnd_rcon,
  output logic         out_rnd_final,
  output logic         out_aes_wr_en,
  output logic [4:0]   out_aes_wr_addr,
  output logic [31:0]  out_aes_wr_data,
  output logic         out_stall,
  output logic         out_busy,
  output logic         out_done,
  output logic [127:0] out_result
);

  localparam int unsigned DATA_W = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned RND_W  = 4;
  localparam int unsigned IDX_W  = 2;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(10);
  localparam logic [IDX_W-1:0] LAST_W   = IDX_W'(WR_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    WB    = 2'd2
  } fsm_t;

  fsm_t               fsm_q;
  fsm_t               fsm_d;
  logic [DATA_W-1:0]  state_reg;
  logic [DATA_W-1:0]  key_reg;
  logic [DATA_W-1:0]  result_q;
  logic [ADDR_W-1:0]  dst_q;
  logic [RND_W-1:0]   rnd_q;
  logic [IDX_W-1:0]   w_q;
  logic               done_q;
  logic               wr_accept;
  logic               last_word;

  // Round constant for the round currently being computed
  function automatic logic [7:0] rcon_of(input logic [RND_W-1:0] r);
    case (r)
      4'd1:    rcon_of = 8'h01;
      4'd2:    rcon_of = 8'h02;
      4'd3:    rcon_of = 8'h04;
      4'd4:    rcon_of = 8'h08;
      4'd5:    rcon_of = 8'h10;
      4'd6:    rcon_of = 8'h20;
      4'd7:    rcon_of = 8'h40;
      4'd8:    rcon_of = 8'h80;
      4'd9:    rcon_of = 8'h1b;
      4'd10:   rcon_of = 8'h36;
      default: rcon_of = 8'h00;
    endcase
  endfunction

  // Pipeline WB has strict priority over the AES write-back
  assign wr_accept = (fsm_q == WB) && !in_wb_regWrite;
  assign last_word = (w_q == LAST_W);

  // FSM state register
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_start) fsm_d = ROUND;
      ROUND:   if (rnd_q == LAST_RND) fsm_d = WB;
      WB:      if (wr_accept && last_word) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Datapath registers: round state/key, counters, result and done pulse
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_reg <= '0;
      key_reg   <= '0;
      result_q  <= '0;
      dst_q     <= '0;
      rnd_q     <= '0;
      w_q       <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= wr_accept && last_word;
      case (fsm_q)
        IDLE: begin
          if (in_start) begin
            key_reg   <= in_cipherkey;
            state_reg <= in_state ^ in_cipherkey;
            dst_q     <= in_dst_base;
            rnd_q     <= RND_W'(1);
            w_q       <= '0;
          end
        end
        ROUND: begin
          state_reg <= in_rnd_state_next;
          key_reg   <= in_rnd_key_next;
          if (rnd_q == LAST_RND) begin
            w_q <= '0;
          end else begin
            rnd_q <= RND_W'(rnd_q + RND_W'(1));
          end
        end
        WB: begin
          if (wr_accept) begin
            if (last_word) begin
              result_q <= state_reg;
            end else begin
              w_q <= IDX_W'(w_q + IDX_W'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from FSM state and datapath registers
  always_comb begin
    out_rnd_rcon    = 8'h00;
    out_rnd_final   = 1'b0;
    out_aes_wr_en   = 1'b0;
    out_aes_wr_addr = '0;
    out_aes_wr_data = '0;
    out_busy        = 1'b0;
    out_stall       = 1'b0;
    case (fsm_q)
      IDLE: begin
        out_stall = in_start;
      end
      ROUND: begin
        out_busy      = 1'b1;
        out_stall     = 1'b1;
        out_rnd_rcon  = rcon_of(rnd_q);
        out_rnd_final = (rnd_q == LAST_RND);
      end
      WB: begin
        out_busy      = 1'b1;
        out_stall     = 1'b1;
        out_aes_wr_en = wr_accept;
        if (wr_accept) begin
          out_aes_wr_addr = ADDR_W'(dst_q + ADDR_W'(w_q));
          case (w_q)
            2'd0:    out_aes_wr_data = state_reg[127:96];
            2'd1:    out_aes_wr_data = state_reg[95:64];
            2'd2:    out_aes_wr_data = state_reg[63:32];
            default: out_aes_wr_data = state_reg[WORD_W-1:0];
          endcase
        end
      end
      default: ;
    endcase
  end

  assign out_rnd_state = state_reg;
  assign out_rnd_key   = key_reg;
  assign out_done      = done_q;
  assign out_result    = result_q;

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Directed bench for aes_seq_ctrl with a behavioural AES-128 round unit.
module tb_aes_seq_ctrl;

  logic         in_clk = 1'b0;
  logic         in_rst = 1'b1;
  logic         in_start = 1'b0;
  logic [127:0] in_cipherkey = '0;
  logic [127:0] in_state = '0;
  logic [4:0]   in_dst_base = '0;
  logic         in_wb_regWrite = 1'b0;
  logic [127:0] in_rnd_state_next;
  logic [127:0] in_rnd_key_next;
  logic [127:0] out_rnd_state;
  logic [127:0] out_rnd_key;
  logic [7:0]   out_rnd_rcon;
  logic         out_rnd_final;
  logic         out_aes_wr_en;
  logic [4:0]   out_aes_wr_addr;
  logic [31:0]  out_aes_wr_data;
  logic         out_stall;
  logic         out_busy;
  logic         out_done;
  logic [127:0] out_result;

  aes_seq_ctrl #(.WR_WORDS(4)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start),
    .in_cipherkey(in_cipherkey), .in_state(in_state), .in_dst_base(in_dst_base),
    .in_wb_regWrite(in_wb_regWrite),
    .in_rnd_state_next(in_rnd_state_next), .in_rnd_key_next(in_rnd_key_next),
    .out_rnd_state(out_rnd_state), .out_rnd_key(out_rnd_key),
    .out_rnd_rcon(out_rnd_rcon), .out_rnd_final(out_rnd_final),
    .out_aes_wr_en(out_aes_wr_en), .out_aes_wr_addr(out_aes_wr_addr),
    .out_aes_wr_data(out_aes_wr_data), .out_stall(out_stall),
    .out_busy(out_busy), .out_done(out_done), .out_result(out_result)
  );

  always #5 in_clk = ~in_clk;

  // ---------------- reference AES round unit ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq = a;
    logic [7:0] r = 8'h01;
    logic [7:0] b;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3 = k[31:0];
    logic [31:0] rot = {w3[23:0], w3[31:24]};
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;
    t  = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r + 4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  assign in_rnd_key_next   = key_exp(out_rnd_key, out_rnd_rcon);
  assign in_rnd_state_next = aes_round(out_rnd_state, in_rnd_key_next, out_rnd_final);

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;

  // per-run observation log
  logic [4:0]  addr_q [$];
  logic [31:0] data_q [$];
  int          edge_q [$];
  int          done_cnt, done_cyc, zero_viol, first_free;
  logic [0:10][7:0] rcon_vec;
  logic [0:10]      fin_vec;
  logic [127:0] pulse_key, pulse_pt;
  logic [4:0]   pulse_dst;

  // Start one operation, then step n_cyc edges (E0..E(n_cyc-1)) logging outputs
  task automatic run_op(input logic [4:0] dst, input logic [127:0] key, input logic [127:0] pt,
                        input int blk_first, input int blk_last, input int pulse_cyc,
                        input int rst_edge, input int n_cyc);
    addr_q.delete(); data_q.delete(); edge_q.delete();
    done_cnt = 0; done_cyc = -1; zero_viol = 0; first_free = -1;
    rcon_vec = '0; fin_vec = '0;
    in_dst_base = dst; in_cipherkey = key; in_state = pt;
    in_start = 1'b1; in_wb_regWrite = 1'b0; in_rst = 1'b0;
    for (int k = 0; k < n_cyc; k++) begin
      @(posedge in_clk);
      #1;
      in_start = (k == pulse_cyc);
      if (k == pulse_cyc) begin
        in_cipherkey = pulse_key; in_state = pulse_pt; in_dst_base = pulse_dst;
      end
      in_wb_regWrite = (k + 1 >= blk_first) && (k + 1 <= blk_last);
      in_rst = (k + 1 == rst_edge);
      #1;
      if (k < 11) begin
        rcon_vec[k] = out_rnd_rcon;
        fin_vec[k]  = out_rnd_final;
      end
      if (out_aes_wr_en && !in_rst) begin
        addr_q.push_back(out_aes_wr_addr);
        data_q.push_back(out_aes_wr_data);
        edge_q.push_back(k + 1);
      end
      if (!out_aes_wr_en && (out_aes_wr_addr != 5'd0 || out_aes_wr_data != 32'd0)) zero_viol++;
      if (out_done) begin
        done_cnt++;
        done_cyc = k;
      end
      if (!out_stall && first_free < 0) first_free = k;
    end
    in_start = 1'b0; in_rst = 1'b0; in_wb_regWrite = 1'b0;
  endtask

  // Compare up to four logged writes starting at log index off
  task automatic check_writes(input string pfx, input int off, input logic [19:0] ea,
                              input logic [127:0] ed, input logic [31:0] ee);
    logic [19:0]  a = '0;
    logic [127:0] d = '0;
    logic [31:0]  e = '0;
    for (int i = 0; i < 4; i++) begin
      if (off + i < addr_q.size()) begin
        a[19-5*i -: 5]  = addr_q[off+i];
        d[127-32*i -: 32] = data_q[off+i];
        e[31-8*i -: 8]  = 8'(edge_q[off+i]);
      end
    end
    check({pfx, "_addr"}, 128'(a), 128'(ea));
    check({pfx, "_data"}, d, ed);
    check({pfx, "_edge"}, 128'(e), 128'(ee));
  endtask

  initial begin
    pulse_key = '0; pulse_pt = '0; pulse_dst = '0;

    // reset with start asserted: reset wins
    in_rst = 1'b1; in_start = 1'b1;
    @(posedge in_clk); #1;
    @(posedge in_clk); #1;
    check("rst_busy",   128'(out_busy), 128'd0);
    check("rst_done",   128'(out_done), 128'd0);
    check("rst_result", out_result, 128'd0);
    check("rst_rstate", out_rnd_state, 128'd0);
    check("rst_rkey",   out_rnd_key, 128'd0);
    check("rst_wr_en",  128'(out_aes_wr_en), 128'd0);
    check("rst_rcon",   128'(out_rnd_rcon), 128'd0);
    check("rst_stall_start", 128'(out_stall), 128'd1);
    in_start = 1'b0; in_rst = 1'b0;
    #1;
    check("rst_stall_idle", 128'(out_stall), 128'd0);

    // A: FIPS-197 C.1 vector, no contention
    run_op(5'd8, KEY1, PT1, -1, -1, -1, -1, 18);
    check("a_nwr", 128'(addr_q.size()), 128'd4);
    check_writes("a", 0, {5'd8, 5'd9, 5'd10, 5'd11}, CT1, {8'd11, 8'd12, 8'd13, 8'd14});
    check("a_done_cnt", 128'(done_cnt), 128'd1);
    check("a_done_cyc", 128'(done_cyc), 128'd14);
    check("a_result", out_result, CT1);
    check("a_rcon", 128'(rcon_vec), 128'(88'h01020408102040801b3600));
    check("a_final", 128'(fin_vec), 128'(11'h002));
    check("a_zero", 128'(zero_viol), 128'd0);
    check("a_free", 128'(first_free), 128'd14);

    // B: pipeline owns the write port at E11..E13
    run_op(5'd8, KEY1, PT1, 11, 13, -1, -1, 20);
    check("b_nwr", 128'(addr_q.size()), 128'd4);
    check_writes("b", 0, {5'd8, 5'd9, 5'd10, 5'd11}, CT1, {8'd14, 8'd15, 8'd16, 8'd17});
    check("b_done_cyc", 128'(done_cyc), 128'd17);
    check("b_zero", 128'(zero_viol), 128'd0);

    // C: destination wraps past register 31
    run_op(5'd30, KEY1, PT1, -1, -1, -1, -1, 18);
    check("c_nwr", 128'(addr_q.size()), 128'd4);
    check_writes("c", 0, {5'd30, 5'd31, 5'd0, 5'd1}, CT1, {8'd11, 8'd12, 8'd13, 8'd14});

    // D: start pulse during round 5 is ignored
    pulse_key = KEY2; pulse_pt = PT2; pulse_dst = 5'd20;
    run_op(5'd8, KEY1, PT1, -1, -1, 4, -1, 20);
    check("d_nwr", 128'(addr_q.size()), 128'd4);
    check_writes("d", 0, {5'd8, 5'd9, 5'd10, 5'd11}, CT1, {8'd11, 8'd12, 8'd13, 8'd14});
    check("d_done_cnt", 128'(done_cnt), 128'd1);
    check("d_result", out_result, CT1);

    // E: reset in WB after word 1 written (reset edge E13)
    run_op(5'd8, KEY1, PT1, -1, -1, -1, 13, 18);
    check("e_nwr", 128'(addr_q.size()), 128'd2);
    check_writes("e", 0, {5'd8, 5'd9, 5'd0, 5'd0},
                 {CT1[127:64], 64'd0}, {8'd11, 8'd12, 8'd0, 8'd0});
    check("e_done_cnt", 128'(done_cnt), 128'd0);
    check("e_result", out_result, 128'd0);
    check("e_busy", 128'(out_busy), 128'd0);
    check("e_rstate", out_rnd_state, 128'd0);

    // F: back-to-back start in the done cycle
    pulse_key = KEY2; pulse_pt = PT2; pulse_dst = 5'd16;
    run_op(5'd8, KEY1, PT1, -1, -1, 14, -1, 33);
    check("f_nwr", 128'(addr_q.size()), 128'd8);
    check_writes("f1", 0, {5'd8, 5'd9, 5'd10, 5'd11}, CT1, {8'd11, 8'd12, 8'd13, 8'd14});
    check_writes("f2", 4, {5'd16, 5'd17, 5'd18, 5'd19}, CT2, {8'd26, 8'd27, 8'd28, 8'd29});
    check("f_done_cnt", 128'(done_cnt), 128'd2);
    check("f_done_cyc", 128'(done_cyc), 128'd29);
    check("f_free", 128'(first_free), 128'd29);
    check("f_result", out_result, CT2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
